// File: rtl/verificador_de_senha.sv
// -----------------------------------------------------------------------------
// verificador_de_senha
//
// Password checker that sits downstream of the keypad decoder. It takes a
// packed word of 20 BCD-style nibbles (nibble 0 = newest digit, unused nibbles
// 0xF) with a one-cycle strobe. It checks the entry against the master
// password and an optional user password. It then either releases the lock
// for T_OPEN cycles, or counts a failure. After MAX_TENT consecutive failures
// it enters a timed lockout and disables the keypad.
//
// Special keypad words:
//   all-0xB : '#', relocks while open; ignored while locked.
//   all-0xE : keypad timeout; ignored.
//
// Optional build macro:
//   ALARME_EN : adds output 'alarme', high for the whole lockout period.
//
// Ports:
//   clk             in   clock, rising edge
//   rst             in   asynchronous reset, active-high
//   digitos_valid   in   1-cycle strobe qualifying digitos_value
//   digitos_value   in   [79:0] entered digits, nibble 0 = bits[3:0]
//   senha_master    in   [79:0] master password, 0xF padded
//   senha_user      in   [79:0] user password, 0xF padded
//   user_en         in   1 = senha_user is accepted
//   tranca          out  1 = locked, 0 = released
//   bloqueado       out  1 during lockout
//   teclado_enable  out  keypad decoder enable, 0 during lockout
//   tentativas      out  consecutive failed attempts
//   resultado_valid out  1-cycle pulse when a check completes
//   resultado_ok    out  match flag, qualified by resultado_valid
//   alarme          out  (ALARME_EN only) mirrors bloqueado
//
// Latency: a strobe in cycle n gives resultado_valid and the updated
// tranca/bloqueado in cycle n+2. All outputs are registered.
// -----------------------------------------------------------------------------
module verificador_de_senha #(
  parameter int MIN_DIGITS = 4,
  parameter int MAX_DIGITS = 12,
  parameter int MAX_TENT   = 3,
  parameter int T_OPEN     = 5000,
  parameter int T_LOCK     = 10000
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           digitos_valid,
  input  logic [79:0]                    digitos_value,
  input  logic [79:0]                    senha_master,
  input  logic [79:0]                    senha_user,
  input  logic                           user_en,
  output logic                           tranca,
  output logic                           bloqueado,
  output logic                           teclado_enable,
  output logic [$clog2(MAX_TENT+1)-1:0]  tentativas,
  output logic                           resultado_valid,
  output logic                           resultado_ok
`ifdef ALARME_EN
  ,
  output logic                           alarme
`endif
);

  localparam int TENT_W = $clog2(MAX_TENT + 1);
  localparam int T_MAX  = (T_OPEN > T_LOCK) ? T_OPEN : T_LOCK;
  localparam int TIM_W  = (T_MAX > 1) ? $clog2(T_MAX) : 1;

  localparam logic [4:0]        MIN_L     = 5'(MIN_DIGITS);
  localparam logic [4:0]        MAX_L     = 5'(MAX_DIGITS);
  localparam logic [TENT_W-1:0] TENT_FULL = TENT_W'(MAX_TENT);
  localparam logic [TIM_W-1:0]  OPEN_LAST = TIM_W'(T_OPEN - 1);
  localparam logic [TIM_W-1:0]  LOCK_LAST = TIM_W'(T_LOCK - 1);

  localparam logic [79:0] WORD_HASH    = {20{4'hB}};
  localparam logic [79:0] WORD_TIMEOUT = {20{4'hE}};

  typedef enum logic [1:0] {
    TRANCADO,
    VERIFICA,
    ABERTO,
    BLOQUEIO
  } state_t;

  state_t              state_q, state_d;
  logic [TIM_W-1:0]    timer_q, timer_d;
  logic [79:0]         entrada_q, entrada_d;
  logic [TENT_W-1:0]   tentativas_q, tentativas_d;
  logic                tranca_q, tranca_d;
  logic                bloqueado_q, bloqueado_d;
  logic                teclado_enable_q, teclado_enable_d;
  logic                resultado_valid_q, resultado_valid_d;
  logic                resultado_ok_q, resultado_ok_d;

  logic                is_hash;
  logic                is_timeout;
  logic [4:0]          len;
  logic                in_run;
  logic                digits_ok;
  logic                pad_ok;
  logic                fmt_ok;
  logic                match;

  assign is_hash    = (digitos_value == WORD_HASH);
  assign is_timeout = (digitos_value == WORD_TIMEOUT);

  // Format scan of the registered entry. The length is the run of non-0xF
  // nibbles starting at nibble 0. Every nibble after the first 0xF must also
  // be 0xF, so an entry with a gap such as ..F1F23 is rejected.
  // NOTE: every variable gets a default before the loop; a path that leaves
  // a combinational variable unassigned infers a latch.
  always_comb begin
    len       = '0;
    in_run    = 1'b1;
    digits_ok = 1'b1;
    pad_ok    = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (in_run && (entrada_q[4*i +: 4] != 4'hF)) begin
        len = len + 5'd1;
        if (entrada_q[4*i +: 4] > 4'd9) digits_ok = 1'b0;
      end else begin
        in_run = 1'b0;
        if (entrada_q[4*i +: 4] != 4'hF) pad_ok = 1'b0;
      end
    end
  end

  assign fmt_ok = (len >= MIN_L) && (len <= MAX_L) && digits_ok && pad_ok;
  assign match  = fmt_ok && ((entrada_q == senha_master) ||
                             (user_en && (entrada_q == senha_user)));

  always_comb begin
    state_d           = state_q;
    timer_d           = timer_q;
    entrada_d         = entrada_q;
    tentativas_d      = tentativas_q;
    tranca_d          = tranca_q;
    bloqueado_d       = bloqueado_q;
    teclado_enable_d  = teclado_enable_q;
    resultado_valid_d = 1'b0;
    resultado_ok_d    = 1'b0;

    unique case (state_q)
      TRANCADO: begin
        if (digitos_valid && !is_hash && !is_timeout) begin
          entrada_d = digitos_value;
          state_d   = VERIFICA;
        end
      end

      // Any strobe arriving here is dropped: entrada is only loaded in
      // TRANCADO.
      VERIFICA: begin
        resultado_valid_d = 1'b1;
        if (match) begin
          resultado_ok_d = 1'b1;
          tentativas_d   = '0;
          tranca_d       = 1'b0;
          state_d        = ABERTO;
        end else if (int'(tentativas_q) + 1 < MAX_TENT) begin
          tentativas_d = tentativas_q + TENT_W'(1);
          state_d      = TRANCADO;
        end else begin
          tentativas_d     = TENT_FULL;
          bloqueado_d      = 1'b1;
          teclado_enable_d = 1'b0;
          state_d          = BLOQUEIO;
        end
      end

      ABERTO: begin
        if ((digitos_valid && is_hash) || (timer_q == OPEN_LAST)) begin
          tranca_d = 1'b1;
          state_d  = TRANCADO;
        end else begin
          timer_d = timer_q + TIM_W'(1);
        end
      end

      BLOQUEIO: begin
        if (timer_q == LOCK_LAST) begin
          tentativas_d     = '0;
          bloqueado_d      = 1'b0;
          teclado_enable_d = 1'b1;
          state_d          = TRANCADO;
        end else begin
          timer_d = timer_q + TIM_W'(1);
        end
      end

      default: state_d = TRANCADO;
    endcase

    // The timer restarts from zero on every state entry. It stops at the
    // last count, so it never wraps.
    if (state_d != state_q) timer_d = '0;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q           <= TRANCADO;
      timer_q           <= '0;
      entrada_q         <= '1;
      tentativas_q      <= '0;
      tranca_q          <= 1'b1;
      bloqueado_q       <= 1'b0;
      teclado_enable_q  <= 1'b1;
      resultado_valid_q <= 1'b0;
      resultado_ok_q    <= 1'b0;
    end else begin
      state_q           <= state_d;
      timer_q           <= timer_d;
      entrada_q         <= entrada_d;
      tentativas_q      <= tentativas_d;
      tranca_q          <= tranca_d;
      bloqueado_q       <= bloqueado_d;
      teclado_enable_q  <= teclado_enable_d;
      resultado_valid_q <= resultado_valid_d;
      resultado_ok_q    <= resultado_ok_d;
    end
  end

  assign tranca          = tranca_q;
  assign bloqueado       = bloqueado_q;
  assign teclado_enable  = teclado_enable_q;
  assign tentativas      = tentativas_q;
  assign resultado_valid = resultado_valid_q;
  assign resultado_ok    = resultado_ok_q;

`ifdef ALARME_EN
  logic alarme_q, alarme_d;

  // Loaded from the same next value as bloqueado, so both rise and fall on
  // the same edge.
  assign alarme_d = bloqueado_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) alarme_q <= 1'b0;
    else     alarme_q <= alarme_d;
  end

  assign alarme = alarme_q;
`endif

endmodule

// File: tb/tb_verificador_de_senha.sv
// -----------------------------------------------------------------------------
// tb_verificador_de_senha
//
// Directed testbench for verificador_de_senha with the default parameters.
// Inputs change on the falling edge, and outputs are sampled on the falling
// edge. A word driven in the cycle before rising edge P1 is therefore
// reported at the falling edge after P2, which is cycle n+2.
// -----------------------------------------------------------------------------
module tb_verificador_de_senha;

  localparam logic [79:0] ALL_F   = {20{4'hF}};
  localparam logic [79:0] ALL_B   = {20{4'hB}};
  localparam logic [79:0] ALL_E   = {20{4'hE}};
  localparam logic [79:0] PW_1234 = {{16{4'hF}}, 16'h1234};
  localparam logic [79:0] PW_5678 = {{16{4'hF}}, 16'h5678};
  localparam logic [79:0] PW_9999 = {{16{4'hF}}, 16'h9999};
  localparam logic [79:0] PW_123  = {{17{4'hF}}, 12'h123};
  localparam logic [79:0] PW_GAP  = {{16{4'hF}}, 16'h1F23};
  localparam logic [79:0] PW_12D  = {{8{4'hF}}, 48'h1234_5678_9012};
  localparam logic [79:0] PW_13D  = {{7{4'hF}}, 52'h1_2345_6789_0123};
  localparam logic [79:0] PW_HEX  = {{16{4'hF}}, 16'h12A4};

  logic        clk;
  logic        rst;
  logic        digitos_valid;
  logic [79:0] digitos_value;
  logic [79:0] senha_master;
  logic [79:0] senha_user;
  logic        user_en;
  logic        tranca;
  logic        bloqueado;
  logic        teclado_enable;
  logic [1:0]  tentativas;
  logic        resultado_valid;
  logic        resultado_ok;
`ifdef ALARME_EN
  logic        alarme;
`endif

  int n_vec = 0;
  int n_err = 0;

  verificador_de_senha dut (
    .clk            (clk),
    .rst            (rst),
    .digitos_valid  (digitos_valid),
    .digitos_value  (digitos_value),
    .senha_master   (senha_master),
    .senha_user     (senha_user),
    .user_en        (user_en),
    .tranca         (tranca),
    .bloqueado      (bloqueado),
    .teclado_enable (teclado_enable),
    .tentativas     (tentativas),
    .resultado_valid(resultado_valid),
    .resultado_ok   (resultado_ok)
`ifdef ALARME_EN
    ,
    .alarme         (alarme)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Strobes one word for a single cycle and returns at the falling edge
  // after the rising edge that sampled it.
  task automatic pulse(input logic [79:0] w);
    @(negedge clk);
    digitos_valid = 1'b1;
    digitos_value = w;
    @(negedge clk);
    digitos_valid = 1'b0;
    digitos_value = ALL_F;
  endtask

  // Compares the outputs of a completed check against the expected values.
  // Called one falling edge after pulse().
  task automatic expect_result(input string name, input logic ok,
                               input logic [1:0] tent, input logic trc,
                               input logic blq);
    n_vec++;
    if ({resultado_valid, resultado_ok, tentativas, tranca, bloqueado} !==
        {1'b1, ok, tent, trc, blq}) begin
      n_err++;
      $display("FAIL %s: got valid=%b ok=%b tent=%0d tranca=%b bloq=%b, expected valid=1 ok=%b tent=%0d tranca=%b bloq=%b",
               name, resultado_valid, resultado_ok, tentativas, tranca, bloqueado,
               ok, tent, trc, blq);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    digitos_valid = 1'b0;
    digitos_value = ALL_F;
    senha_master = PW_1234;
    senha_user = PW_5678;
    user_en = 1'b0;
    repeat (3) @(negedge clk);
    n_vec++;
    if ({tranca, bloqueado, teclado_enable, tentativas, resultado_valid, resultado_ok} !==
        {1'b1, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL reset_values: got tranca=%b bloq=%b kbd=%b tent=%0d rv=%b ok=%b, expected 1 0 1 0 0 0",
               tranca, bloqueado, teclado_enable, tentativas, resultado_valid, resultado_ok);
    end
`ifdef ALARME_EN
    n_vec++;
    if (alarme !== 1'b0) begin
      n_err++;
      $display("FAIL reset_alarme: got %b expected 0", alarme);
    end
`endif
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_match_open;
    int cnt;
    pulse(PW_1234);
    n_vec++;
    if (resultado_valid !== 1'b0 || tranca !== 1'b1) begin
      n_err++;
      $display("FAIL latency_n1: got rv=%b tranca=%b expected rv=0 tranca=1", resultado_valid, tranca);
    end
    @(negedge clk);
    expect_result("master_match", 1'b1, 2'd0, 1'b0, 1'b0);
    cnt = 1;
    for (int i = 0; i < 6000; i++) begin
      @(negedge clk);
      if (tranca !== 1'b0) break;
      cnt++;
    end
    n_vec++;
    if (cnt != 5000 || tranca !== 1'b1) begin
      n_err++;
      $display("FAIL open_duration: got %0d cycles tranca=%b expected 5000 cycles then tranca=1", cnt, tranca);
    end
  endtask

  task automatic test_hash_relock;
    int cnt;
    pulse(PW_1234);
    @(negedge clk);
    expect_result("open_for_hash", 1'b1, 2'd0, 1'b0, 1'b0);
    repeat (95) @(negedge clk);
    pulse(PW_9999);
    @(negedge clk);
    n_vec++;
    if (tranca !== 1'b0 || resultado_valid !== 1'b0 || tentativas !== 2'd0) begin
      n_err++;
      $display("FAIL open_ignores_word: got tranca=%b rv=%b tent=%0d expected 0 0 0",
               tranca, resultado_valid, tentativas);
    end
    pulse(ALL_B);
    n_vec++;
    if (tranca !== 1'b1 || resultado_valid !== 1'b0) begin
      n_err++;
      $display("FAIL hash_relock: got tranca=%b rv=%b expected tranca=1 rv=0", tranca, resultado_valid);
    end
    @(negedge clk);
    n_vec++;
    if (resultado_valid !== 1'b0 || tranca !== 1'b1) begin
      n_err++;
      $display("FAIL hash_no_result: got rv=%b tranca=%b expected rv=0 tranca=1", resultado_valid, tranca);
    end
    // A fresh opening must again last the full period.
    pulse(PW_1234);
    @(negedge clk);
    expect_result("reopen", 1'b1, 2'd0, 1'b0, 1'b0);
    cnt = 1;
    for (int i = 0; i < 6000; i++) begin
      @(negedge clk);
      if (tranca !== 1'b0) break;
      cnt++;
    end
    n_vec++;
    if (cnt != 5000) begin
      n_err++;
      $display("FAIL reopen_duration: got %0d cycles expected 5000", cnt);
    end
  endtask

  task automatic test_ignored_words;
    pulse(PW_9999);
    @(negedge clk);
    expect_result("wrong_before_ignored", 1'b0, 2'd1, 1'b1, 1'b0);
    pulse(ALL_E);
    @(negedge clk);
    n_vec++;
    if (resultado_valid !== 1'b0 || tentativas !== 2'd1) begin
      n_err++;
      $display("FAIL timeout_ignored: got rv=%b tent=%0d expected rv=0 tent=1", resultado_valid, tentativas);
    end
    pulse(ALL_B);
    @(negedge clk);
    n_vec++;
    if (resultado_valid !== 1'b0 || tentativas !== 2'd1 || tranca !== 1'b1) begin
      n_err++;
      $display("FAIL hash_locked_ignored: got rv=%b tent=%0d tranca=%b expected 0 1 1",
               resultado_valid, tentativas, tranca);
    end
    pulse(PW_1234);
    @(negedge clk);
    expect_result("match_clears_count", 1'b1, 2'd0, 1'b0, 1'b0);
    pulse(ALL_B);
  endtask

  task automatic test_format;
    senha_master = PW_123;
    pulse(PW_123);
    @(negedge clk);
    expect_result("short_len3", 1'b0, 2'd1, 1'b1, 1'b0);
    pulse(PW_GAP);
    @(negedge clk);
    expect_result("gap_word", 1'b0, 2'd2, 1'b1, 1'b0);
    senha_master = PW_12D;
    pulse(PW_12D);
    @(negedge clk);
    expect_result("len12_max", 1'b1, 2'd0, 1'b0, 1'b0);
    pulse(ALL_B);
    senha_master = PW_13D;
    pulse(PW_13D);
    @(negedge clk);
    expect_result("len13_over", 1'b0, 2'd1, 1'b1, 1'b0);
    senha_master = PW_HEX;
    pulse(PW_HEX);
    @(negedge clk);
    expect_result("non_digit", 1'b0, 2'd2, 1'b1, 1'b0);
    senha_master = PW_1234;
    pulse(PW_1234);
    @(negedge clk);
    expect_result("restore_master", 1'b1, 2'd0, 1'b0, 1'b0);
    pulse(ALL_B);
  endtask

  task automatic test_user_en;
    user_en = 1'b0;
    pulse(PW_5678);
    @(negedge clk);
    expect_result("user_disabled", 1'b0, 2'd1, 1'b1, 1'b0);
    user_en = 1'b1;
    pulse(PW_5678);
    @(negedge clk);
    expect_result("user_enabled", 1'b1, 2'd0, 1'b0, 1'b0);
    pulse(ALL_B);
    user_en = 1'b0;
  endtask

  task automatic test_back_to_back;
    // Second strobe lands while the first is being verified and is dropped.
    @(negedge clk);
    digitos_valid = 1'b1;
    digitos_value = PW_9999;
    @(negedge clk);
    digitos_value = PW_1234;
    @(negedge clk);
    digitos_valid = 1'b0;
    digitos_value = ALL_F;
    expect_result("b2b_first", 1'b0, 2'd1, 1'b1, 1'b0);
    @(negedge clk);
    n_vec++;
    if (resultado_valid !== 1'b0 || tranca !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_dropped: got rv=%b tranca=%b expected rv=0 tranca=1", resultado_valid, tranca);
    end
    @(negedge clk);
    n_vec++;
    if (resultado_valid !== 1'b0 || tentativas !== 2'd1) begin
      n_err++;
      $display("FAIL b2b_quiet: got rv=%b tent=%0d expected rv=0 tent=1", resultado_valid, tentativas);
    end
    pulse(PW_1234);
    @(negedge clk);
    expect_result("b2b_recover", 1'b1, 2'd0, 1'b0, 1'b0);
    pulse(ALL_B);
  endtask

  task automatic test_lockout;
    int bad;
    pulse(PW_9999);
    @(negedge clk);
    expect_result("fail_1", 1'b0, 2'd1, 1'b1, 1'b0);
    pulse(PW_9999);
    @(negedge clk);
    expect_result("fail_2", 1'b0, 2'd2, 1'b1, 1'b0);
    pulse(PW_9999);
    @(negedge clk);
    expect_result("fail_3", 1'b0, 2'd3, 1'b1, 1'b1);
    n_vec++;
    if (teclado_enable !== 1'b0) begin
      n_err++;
      $display("FAIL lock_kbd: got %b expected 0", teclado_enable);
    end
    bad = 0;
    for (int i = 1; i < 10000; i++) begin
      @(negedge clk);
      if (bloqueado !== 1'b1 || teclado_enable !== 1'b0 || resultado_valid !== 1'b0) bad++;
`ifdef ALARME_EN
      if (alarme !== 1'b1) bad++;
`endif
      // A correct entry during lockout must be ignored.
      digitos_valid = (i == 50);
      digitos_value = (i == 50) ? PW_1234 : ALL_F;
    end
    n_vec++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL lock_hold: got %0d bad cycles expected 0", bad);
    end
    @(negedge clk);
    n_vec++;
    if ({bloqueado, teclado_enable, tentativas, tranca} !== {1'b0, 1'b1, 2'd0, 1'b1}) begin
      n_err++;
      $display("FAIL lock_end: got bloq=%b kbd=%b tent=%0d tranca=%b expected 0 1 0 1",
               bloqueado, teclado_enable, tentativas, tranca);
    end
`ifdef ALARME_EN
    n_vec++;
    if (alarme !== 1'b0) begin
      n_err++;
      $display("FAIL alarme_end: got %b expected 0", alarme);
    end
`endif
  endtask

  task automatic test_reset_in_lockout;
    repeat (3) begin
      pulse(PW_9999);
      @(negedge clk);
    end
    n_vec++;
    if (bloqueado !== 1'b1) begin
      n_err++;
      $display("FAIL relock_entry: got bloq=%b expected 1", bloqueado);
    end
    repeat (500) @(negedge clk);
    rst = 1'b1;
    #1;
    n_vec++;
    if ({tranca, bloqueado, teclado_enable, tentativas, resultado_valid, resultado_ok} !==
        {1'b1, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL reset_in_lock: got tranca=%b bloq=%b kbd=%b tent=%0d rv=%b ok=%b expected 1 0 1 0 0 0",
               tranca, bloqueado, teclado_enable, tentativas, resultado_valid, resultado_ok);
    end
    @(negedge clk);
    rst = 1'b0;
    pulse(PW_1234);
    @(negedge clk);
    expect_result("after_reset_match", 1'b1, 2'd0, 1'b0, 1'b0);
    pulse(ALL_B);
  endtask

  initial begin
    test_reset();
    test_match_open();
    test_hash_relock();
    test_ignored_words();
    test_format();
    test_user_en();
    test_back_to_back();
    test_lockout();
    test_reset_in_lockout();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
